// File: rtl/yuv_pkg.sv
// yuv_pkg
// Shared types and default widths for the YUV 4:2:2 pair sequencer.
//   Y_W          : luma width (unsigned)
//   C_W          : chroma width (signed)
//   CONV_LATENCY : register stages inside the shared YUV->RGB converter
//   rgb888_t     : packed 8:8:8 pixel
//   pix_tag_t    : per-pixel tag travelling alongside the converter
//   rgb_beat_t   : one output FIFO entry
package yuv_pkg;

    localparam int Y_W          = 12;
    localparam int C_W          = 12;
    localparam int CONV_LATENCY = 3;

    typedef logic [23:0] rgb888_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
    } pix_tag_t;

    typedef struct packed {
        rgb888_t rgb;
        logic    sof;
        logic    eol;
    } rgb_beat_t;

endpackage

// File: rtl/yuv_sync_fifo.sv
// yuv_sync_fifo
// First-word-fall-through synchronous FIFO of rgb_beat_t.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   wr_en      : push wr_data (ignored while full)
//   rd_en      : pop head (ignored while empty)
//   rd_data    : current head, valid whenever empty=0
//   full/empty : occupancy flags
//   count      : occupancy, 0..DEPTH
module yuv_sync_fifo
    import yuv_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  rgb_beat_t                  wr_data,
    input  logic                       rd_en,
    output rgb_beat_t                  rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rgb_beat_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            wr_ok;
    logic            rd_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; the pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/yuv_pair_sequencer.sv
// yuv_pair_sequencer
// Splits 4:2:2 sample pairs into one pixel per clock for the shared,
// non-stallable YUV->RGB converter, re-aligns sof/eol with the converter
// output and buffers the results in a FWFT FIFO. Input acceptance is
// credit-gated so the FIFO can never overflow.
//   s_*      : sample-pair input stream (valid/ready)
//   conv_*   : converter drive (conv_rst = ~rst_n) and its 24-bit result
//   m_*      : RGB888 output stream (valid/ready), data zeroed when idle
//   busy     : pair in progress or any pixel reserved downstream
//
// state  | meaning
// IDLE   | pixel 0 of a pair may be issued on handshake
// SECOND | pixel 1 of the held pair is issued on the next edge
module yuv_pair_sequencer #(
    parameter int CONV_LATENCY = yuv_pkg::CONV_LATENCY,
    parameter int FIFO_DEPTH   = 8,
    parameter int Y_W          = yuv_pkg::Y_W,
    parameter int C_W          = yuv_pkg::C_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [Y_W-1:0]        s_y0,
    input  logic [Y_W-1:0]        s_y1,
    input  logic signed [C_W-1:0] s_u,
    input  logic signed [C_W-1:0] s_v,
    input  logic                  s_sof,
    input  logic                  s_eol,
    output logic                  conv_rst,
    output logic signed [Y_W:0]   conv_y,
    output logic signed [C_W-1:0] conv_u,
    output logic signed [C_W-1:0] conv_v,
    input  logic [23:0]           conv_rgb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [23:0]           m_rgb,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  busy
);

    import yuv_pkg::*;

    localparam int RW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [Y_W-1:0]  y1_hold;
    logic            eol_hold;
    pix_tag_t        tags [CONV_LATENCY+1];
    logic [RW-1:0]   reserved;
    logic [RW-1:0]   reserved_nxt;
    logic            accept;
    logic            pop;
    logic            fifo_wr;
    rgb_beat_t       fifo_din;
    rgb_beat_t       fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic [RW-1:0]   fifo_count;
    int              tag_cnt;

    assign conv_rst = ~rst_n;
    assign accept   = s_valid && s_ready;
    assign pop      = m_valid && m_ready;

    // The tag leaving the last stage lines up with conv_rgb for that pixel.
    assign fifo_wr  = tags[CONV_LATENCY].valid;
    assign fifo_din = '{rgb: conv_rgb, sof: tags[CONV_LATENCY].sof, eol: tags[CONV_LATENCY].eol};

    // Credits: each accepted pair reserves two FIFO slots up front, released
    // one at a time as beats leave, so in-flight pixels always have room.
    always_comb begin
        reserved_nxt = reserved;
        if (accept) begin
            reserved_nxt = reserved_nxt + RW'(2);
        end
        if (pop) begin
            reserved_nxt = reserved_nxt - RW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SECOND;
            SECOND:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            conv_y   <= '0;
            conv_u   <= '0;
            conv_v   <= '0;
            y1_hold  <= '0;
            eol_hold <= 1'b0;
            reserved <= '0;
            s_ready  <= 1'b0;
            for (int i = 0; i <= CONV_LATENCY; i++) begin
                tags[i] <= '0;
            end
        end else begin
            tags[0] <= '0;
            for (int i = 1; i <= CONV_LATENCY; i++) begin
                tags[i] <= tags[i-1];
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        conv_y   <= {1'b0, s_y0};
                        conv_u   <= s_u;
                        conv_v   <= s_v;
                        y1_hold  <= s_y1;
                        eol_hold <= s_eol;
                        tags[0]  <= '{valid: 1'b1, sof: s_sof, eol: 1'b0};
                    end
                end
                SECOND: begin
                    conv_y  <= {1'b0, y1_hold};
                    tags[0] <= '{valid: 1'b1, sof: 1'b0, eol: eol_hold};
                end
                default: ;
            endcase
            state    <= state_nxt;
            reserved <= reserved_nxt;
            // Registered from next-state values: no path from m_ready/s_valid.
            s_ready  <= (state_nxt == IDLE) && (reserved_nxt <= RW'(FIFO_DEPTH - 2));
        end
    end

    yuv_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid = !fifo_empty;
    assign m_rgb   = m_valid ? fifo_dout.rgb : '0;
    assign m_sof   = m_valid && fifo_dout.sof;
    assign m_eol   = m_valid && fifo_dout.eol;
    assign busy    = (state != IDLE) || (reserved != '0);

    always_comb begin
        tag_cnt = 0;
        for (int i = 0; i <= CONV_LATENCY; i++) begin
            if (tags[i].valid) begin
                tag_cnt = tag_cnt + 1;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && fifo_full))
        else $error("fifo write while full");

    a_credit_balance: assert property (@(posedge clk) disable iff (!rst_n)
        int'(reserved) == int'(fifo_count) + tag_cnt + ((state == SECOND) ? 1 : 0))
        else $error("reserved out of balance");

endmodule

// File: tb/tb_yuv_pair_sequencer.sv
module tb_yuv_pair_sequencer;

    localparam int Y_W = 12;
    localparam int C_W = 12;

    logic                  clk;
    logic                  rst_n;
    logic                  s_valid;
    logic                  s_ready;
    logic [Y_W-1:0]        s_y0;
    logic [Y_W-1:0]        s_y1;
    logic signed [C_W-1:0] s_u;
    logic signed [C_W-1:0] s_v;
    logic                  s_sof;
    logic                  s_eol;
    logic                  conv_rst;
    logic signed [Y_W:0]   conv_y;
    logic signed [C_W-1:0] conv_u;
    logic signed [C_W-1:0] conv_v;
    logic [23:0]           conv_rgb;
    logic                  m_valid;
    logic                  m_ready;
    logic [23:0]           m_rgb;
    logic                  m_sof;
    logic                  m_eol;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    yuv_pair_sequencer #(
        .CONV_LATENCY (3),
        .FIFO_DEPTH   (8),
        .Y_W          (Y_W),
        .C_W          (C_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_y0     (s_y0),
        .s_y1     (s_y1),
        .s_u      (s_u),
        .s_v      (s_v),
        .s_sof    (s_sof),
        .s_eol    (s_eol),
        .conv_rst (conv_rst),
        .conv_y   (conv_y),
        .conv_u   (conv_u),
        .conv_v   (conv_v),
        .conv_rgb (conv_rgb),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_rgb    (m_rgb),
        .m_sof    (m_sof),
        .m_eol    (m_eol),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converter stand-in: analog-YUV style coefficients in Q10, 12-bit
    // result clamped then truncated to 8 bits, three register stages.
    function automatic logic [7:0] clamp8(input int x);
        int c;
        c = (x < 0) ? 0 : ((x > 4095) ? 4095 : x);
        c = c >> 4;
        return c[7:0];
    endfunction

    function automatic logic [23:0] yuv2rgb(input int y, input int u, input int v);
        int r, g, b;
        r = y + ((1167 * v) >>> 10);
        g = y - ((404 * u) >>> 10) - ((595 * v) >>> 10);
        b = y + ((2081 * u) >>> 10);
        return {clamp8(r), clamp8(g), clamp8(b)};
    endfunction

    logic [23:0] cs1 = '0;
    logic [23:0] cs2 = '0;
    logic [23:0] cs3 = '0;
    always @(posedge clk) begin
        cs1 <= yuv2rgb(int'(conv_y), int'(conv_u), int'(conv_v));
        cs2 <= cs1;
        cs3 <= cs2;
    end
    assign conv_rgb = cs3;

    function automatic logic [23:0] gray(input int g);
        return {g[7:0], g[7:0], g[7:0]};
    endfunction

    function automatic logic [31:0] beat(input logic v, input logic sof, input logic eol,
                                         input logic [23:0] rgb);
        return {5'b0, v, sof, eol, rgb};
    endfunction

    function automatic logic [31:0] obs_beat();
        return {5'b0, m_valid, m_sof, m_eol, m_rgb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_pair(input int y0, input int y1, input int u, input int v,
                             input logic sof, input logic eol);
        int  n;
        bit  done;
        n    = 0;
        done = 0;
        s_y0 = 12'(y0);
        s_y1 = 12'(y1);
        s_u  = 12'(u);
        s_v  = 12'(v);
        s_sof = sof;
        s_eol = eol;
        s_valid = 1'b1;
        while (!done) begin
            if (s_ready) begin
                @(posedge clk);
                done = 1;
                @(negedge clk);
            end else begin
                n++;
                if (n > 60) begin
                    errors++;
                    $error("FAIL send_pair timeout observed=no_accept expected=accept");
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  sof_pat;
        logic [3:0]  eol_pat;
        logic [23:0] exp_rgb;
        bit          ok;
        int          n;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_y0 = '0; s_y1 = '0; s_u = '0; s_v = '0; s_sof = 1'b0; s_eol = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_conv_rst", 32'(conv_rst), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_conv_y", 32'(conv_y), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_conv_rst", 32'(conv_rst), 32'd0);

        // T1: white then black, latency E0+4 / E0+5
        m_ready = 1'b1;
        send_pair(4095, 0, 0, 0, 1'b1, 1'b1);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_latency_idle", 32'(m_valid), 32'd0);
            @(negedge clk);
        end
        check("t1_beat0", obs_beat(), beat(1'b1, 1'b1, 1'b0, 24'hFFFFFF));
        @(negedge clk);
        check("t1_beat1", obs_beat(), beat(1'b1, 1'b0, 1'b1, 24'h000000));
        @(negedge clk);
        check("t1_empty", obs_beat(), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);

        // T2: Y=2048, U=0, V=1000 -> R=199 G=91 B=128
        send_pair(2048, 2048, 0, 1000, 1'b0, 1'b0);
        s_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("t2_beat0", obs_beat(), beat(1'b1, 1'b0, 1'b0, 24'hC75B80));
        @(negedge clk);
        check("t2_beat1", obs_beat(), beat(1'b1, 1'b0, 1'b0, 24'hC75B80));
        @(negedge clk);
        check("t2_empty", 32'(m_valid), 32'd0);

        // T3/T4: back-pressure fills exactly 4 pairs; a 5th waits on credit
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_pair((10 + 2 * k) * 16, (11 + 2 * k) * 16, 0, 0, (k == 0), 1'b1);
        end
        s_y0 = 12'(80 * 16); s_y1 = 12'(81 * 16); s_u = '0; s_v = '0;
        s_sof = 1'b0; s_eol = 1'b1; s_valid = 1'b1;
        ok = 1;
        repeat (20) begin
            if (s_ready) ok = 0;
            @(negedge clk);
        end
        check("t3_blocked", 32'(ok), 32'd1);
        check("t3_reserved_full", 32'(dut.reserved), 32'd8);
        m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_rgb = (k < 8) ? gray(10 + k) : gray(72 + k);
            check("t3_drain_beat", obs_beat(), beat(1'b1, (k == 0), k[0], exp_rgb));
            if (k == 1) begin
                check("t4_reserved7", 32'(dut.reserved), 32'd7);
                check("t4_s_ready_r7", 32'(s_ready), 32'd0);
            end
            if (k == 2) begin
                check("t4_reserved6", 32'(dut.reserved), 32'd6);
                check("t4_s_ready_r6", 32'(s_ready), 32'd1);
            end
            if (k == 3) begin
                check("t4_accept_pop", 32'(dut.reserved), 32'd7);
                s_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("t3_no_dup", 32'(m_valid), 32'd0);
        check("t3_busy", 32'(busy), 32'd0);

        // T5: back-to-back pairs, tag patterns, sustained 1 beat/clk
        sof_pat = 4'b0101;
        eol_pat = 4'b1010;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send_pair((40 + 2 * k) * 16, (41 + 2 * k) * 16, 0, 0, sof_pat[k], eol_pat[k]);
                end
                s_valid = 1'b0;
            end
            begin
                n = 0;
                while (!m_valid && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                check("t5_start", 32'(m_valid), 32'd1);
                for (int j = 0; j < 8; j++) begin
                    check("t5_beat", obs_beat(),
                          beat(1'b1, j[0] ? 1'b0 : sof_pat[j/2], j[0] ? eol_pat[j/2] : 1'b0,
                               gray(40 + j)));
                    @(negedge clk);
                end
                check("t5_end", 32'(m_valid), 32'd0);
            end
        join

        // T6: async reset with pixels in the pipe and in the FIFO
        m_ready = 1'b0;
        send_pair(20 * 16, 21 * 16, 0, 0, 1'b1, 1'b0);
        send_pair(22 * 16, 23 * 16, 0, 0, 1'b0, 1'b0);
        send_pair(24 * 16, 25 * 16, 0, 0, 1'b0, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        check("t6_pre_fifo", 32'(dut.fifo_count), 32'd2);
        check("t6_pre_m_valid", 32'(m_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", 32'(m_valid), 32'd0);
        check("t6_rst_s_ready", 32'(s_ready), 32'd0);
        check("t6_rst_conv_rst", 32'(conv_rst), 32'd1);
        check("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (m_valid) ok = 0;
        end
        check("t6_no_stale", 32'(ok), 32'd1);
        send_pair(30 * 16, 31 * 16, 0, 0, 1'b1, 1'b1);
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6_latency_idle", 32'(m_valid), 32'd0);
            @(negedge clk);
        end
        check("t6_beat0", obs_beat(), beat(1'b1, 1'b1, 1'b0, gray(30)));
        @(negedge clk);
        check("t6_beat1", obs_beat(), beat(1'b1, 1'b0, 1'b1, gray(31)));
        @(negedge clk);
        check("t6_empty", 32'(m_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
